// File: rtl/axi_ram_2p_burst.sv
`default_nettype none
// ============================================================================
// Module  : axi_ram_2p_burst
// Brief   : AXI4 slave over a simple-dual-port RAM (write port A, read port B)
//           with FIXED/INCR/WRAP bursts, WSTRB and SLVERR on out-of-range beats.
// Revision: 1.0  initial release
// ============================================================================
module axi_ram_2p_burst #(
  parameter int G_DATAWIDTH  = 32,
  parameter int G_MEMDEPTH   = 1024,
  parameter int G_ID_WIDTH   = 1,
  parameter int G_AXI_AWIDTH = 32,
  parameter     G_INIT_FILE  = ""
) (
  input  logic                      s_aclk,
  input  logic                      s_aresetn,
  input  logic [G_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [G_AXI_AWIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [G_DATAWIDTH-1:0]    s_axi_wdata,
  input  logic [G_DATAWIDTH/8-1:0]  s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [G_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [G_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [G_AXI_AWIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [G_ID_WIDTH-1:0]     s_axi_rid,
  output logic [G_DATAWIDTH-1:0]    s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int C_WEW  = G_DATAWIDTH / 8;
  localparam int C_LSB  = $clog2(C_WEW);
  localparam int C_IDXW = $clog2(G_MEMDEPTH);
  localparam logic [G_AXI_AWIDTH:0] C_MEM_BYTES = (G_AXI_AWIDTH+1)'(G_MEMDEPTH * C_WEW);
  localparam logic [2:0] C_MAX_SIZE = 3'(C_LSB);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  function automatic logic [G_AXI_AWIDTH-1:0] f_next_addr(
    input logic [G_AXI_AWIDTH-1:0] addr,
    input logic [2:0]              size,
    input logic [7:0]              len,
    input logic [1:0]              burst
  );
    logic [G_AXI_AWIDTH-1:0] step;
    logic [G_AXI_AWIDTH-1:0] mask;
    step = G_AXI_AWIDTH'(1) << size;
    mask = ((G_AXI_AWIDTH'(len) + G_AXI_AWIDTH'(1)) << size) - G_AXI_AWIDTH'(1);
    case (burst)
      2'b00:   f_next_addr = addr;
      2'b10:   f_next_addr = (addr & ~mask) | ((addr + step) & mask);
      default: f_next_addr = addr + step;
    endcase
  endfunction

  logic [G_DATAWIDTH-1:0] mem_q [G_MEMDEPTH];

  // Outputs stay low during reset and for the first cycle after release.
  logic run_q;
  logic w_active;
  assign w_active = s_aresetn & run_q;

  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) run_q <= 1'b0;
    else            run_q <= 1'b1;
  end

  // ---------------------------------------------------------------- write
  wstate_t                 w_state_q, w_state_d;
  logic [G_ID_WIDTH-1:0]   aw_id_q;
  logic [G_AXI_AWIDTH-1:0] aw_addr_q;
  logic [7:0]              aw_len_q, w_cnt_q;
  logic [2:0]              aw_size_q;
  logic [1:0]              aw_burst_q;
  logic                    w_err_q;
  logic w_aw_hs, w_wr_hs, w_wr_last, w_wr_inrange, w_wr_err;

  assign w_aw_hs      = w_active & (w_state_q == W_IDLE) & s_axi_awvalid;
  assign w_wr_hs      = w_active & (w_state_q == W_DATA) & s_axi_wvalid;
  assign w_wr_last    = (w_cnt_q == aw_len_q);
  assign w_wr_inrange = ({1'b0, aw_addr_q} < C_MEM_BYTES);
  assign w_wr_err     = ~w_wr_inrange | (s_axi_wlast != w_wr_last);

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (w_aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_wr_hs && w_wr_last) w_state_d = W_RESP;
      W_RESP:  if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (w_aw_hs) begin
        aw_id_q    <= s_axi_awid;
        aw_addr_q  <= s_axi_awaddr;
        aw_len_q   <= s_axi_awlen;
        aw_size_q  <= (s_axi_awsize > C_MAX_SIZE) ? C_MAX_SIZE : s_axi_awsize;
        aw_burst_q <= s_axi_awburst;
        w_cnt_q    <= '0;
        w_err_q    <= 1'b0;
      end else if (w_wr_hs) begin
        aw_addr_q <= f_next_addr(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q);
        w_cnt_q   <= w_cnt_q + 8'd1;
        if (w_wr_err) w_err_q <= 1'b1;
      end
    end
  end

  assign s_axi_awready = w_active & (w_state_q == W_IDLE);
  assign s_axi_wready  = w_active & (w_state_q == W_DATA);
  assign s_axi_bvalid  = w_active & (w_state_q == W_RESP);
  assign s_axi_bid     = w_active ? aw_id_q : '0;
  assign s_axi_bresp   = (s_axi_bvalid & w_err_q) ? 2'b10 : 2'b00;

  // ----------------------------------------------------------------- read
  rstate_t                 r_state_q, r_state_d;
  logic [G_ID_WIDTH-1:0]   ar_id_q;
  logic [G_AXI_AWIDTH-1:0] ar_addr_q;
  logic [7:0]              ar_len_q, r_cnt_q;
  logic [2:0]              ar_size_q;
  logic [1:0]              ar_burst_q;
  logic                    r_done_q;
  // s1 = RAM output register, out = AXI R register; s1 stalls when out is held.
  logic                    s1_valid_q, s1_oor_q, s1_last_q;
  logic [G_DATAWIDTH-1:0]  s1_data_q;
  logic                    rvalid_q, rlast_q;
  logic [1:0]              rresp_q;
  logic [G_DATAWIDTH-1:0]  rdata_q;
  logic w_ar_hs, w_r_hs, w_out_ready, w_s1_ready, w_issue, w_rd_inrange;

  assign w_ar_hs      = w_active & (r_state_q == R_IDLE) & s_axi_arvalid;
  assign w_r_hs       = w_active & rvalid_q & s_axi_rready;
  assign w_out_ready  = ~rvalid_q | s_axi_rready;
  assign w_s1_ready   = ~s1_valid_q | w_out_ready;
  assign w_issue      = w_active & (r_state_q == R_DATA) & ~r_done_q & w_s1_ready;
  assign w_rd_inrange = ({1'b0, ar_addr_q} < C_MEM_BYTES);

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (w_ar_hs) r_state_d = R_DATA;
      R_DATA:  if (w_r_hs && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      r_done_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_oor_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (w_ar_hs) begin
        ar_id_q    <= s_axi_arid;
        ar_addr_q  <= s_axi_araddr;
        ar_len_q   <= s_axi_arlen;
        ar_size_q  <= (s_axi_arsize > C_MAX_SIZE) ? C_MAX_SIZE : s_axi_arsize;
        ar_burst_q <= s_axi_arburst;
        r_cnt_q    <= '0;
        r_done_q   <= 1'b0;
      end else if (w_issue) begin
        ar_addr_q <= f_next_addr(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q);
        r_cnt_q   <= r_cnt_q + 8'd1;
        if (r_cnt_q == ar_len_q) r_done_q <= 1'b1;
      end
      if (w_issue) begin
        s1_valid_q <= 1'b1;
        s1_oor_q   <= ~w_rd_inrange;
        s1_last_q  <= (r_cnt_q == ar_len_q);
      end else if (w_out_ready) begin
        s1_valid_q <= 1'b0;
      end
      if (w_out_ready) begin
        rvalid_q <= s1_valid_q;
        rdata_q  <= s1_oor_q ? '0 : s1_data_q;
        rresp_q  <= s1_oor_q ? 2'b10 : 2'b00;
        rlast_q  <= s1_last_q;
      end
    end
  end

  // RAM ports; a same-word read and write in one cycle returns the old word.
  always_ff @(posedge s_aclk) begin
    if (w_wr_hs && w_wr_inrange) begin
      for (int b = 0; b < C_WEW; b++) begin
        if (s_axi_wstrb[b]) mem_q[aw_addr_q[C_LSB +: C_IDXW]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
    if (w_issue) s1_data_q <= mem_q[ar_addr_q[C_LSB +: C_IDXW]];
  end

  assign s_axi_arready = w_active & (r_state_q == R_IDLE);
  assign s_axi_rvalid  = w_active & rvalid_q;
  assign s_axi_rid     = w_active ? ar_id_q : '0;
  assign s_axi_rdata   = w_active ? rdata_q : '0;
  assign s_axi_rresp   = w_active ? rresp_q : 2'b00;
  assign s_axi_rlast   = w_active & rlast_q;

endmodule
`default_nettype wire
